arm_pipelined_cond_exec_unit: RTL and testbench

- Execute-stage conditional-execution unit for the pipelined ARM core.
- Holds the architectural NZCV flag register and evaluates the 4-bit condition field against it.
- Gates the PC-source, register-write and memory-write strobes of the instruction currently in Execute.
- Adds two things the single-cycle condition checker lacks: stall/flush handling and an IT-block (if-then) sequencer that supplies conditions for up to IT_MAX following instructions.

---
 rtl/arm_pipelined_cond_exec_unit.sv | 182 ++++++++++++++++++
 tb/tb_arm_pipelined_cond_exec_unit.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arm_pipelined_cond_exec_unit.sv
// Execute-stage conditional-execution unit: NZCV flag register, ARM condition decode,
// write-strobe gating with stall/flush, and an IT-block sequencer. Optional macro: ARM_COND_STICKY_Q_EN.
module arm_pipelined_cond_exec_unit #(
    parameter int          IT_MAX     = 4,
    parameter logic [3:0]  FLAG_RESET = 4'b0000,
    parameter int          IT_CNT_W   = $clog2(IT_MAX + 1)
) (
    input  logic                i_CLK,
    input  logic                i_RESET,
    input  logic                i_Valid,
    input  logic                i_Stall,
    input  logic                i_Flush,
    input  logic [3:0]          i_Cond,
    input  logic [3:0]          i_ALU_Flags,
    input  logic [1:0]          i_Flag_Write,
    input  logic                i_PC_Src,
    input  logic                i_Reg_Write,
    input  logic                i_Mem_Write,
    input  logic                i_No_Write,
    input  logic                i_IT_Start,
    input  logic [3:0]          i_IT_FirstCond,
    input  logic [IT_CNT_W-1:0] i_IT_Len,
    input  logic [IT_MAX-1:0]   i_IT_Else,
`ifdef ARM_COND_STICKY_Q_EN
    input  logic                i_Sat,
    input  logic                i_Q_Clear,
    output logic                o_Q_Flag,
`endif
    output logic                o_Cond_Ex,
    output logic                o_PC_Src,
    output logic                o_Reg_Write,
    output logic                o_Mem_Write,
    output logic [3:0]          o_Flags,
    output logic                o_IT_Active,
    output logic [IT_CNT_W-1:0] o_IT_Remaining
);

    typedef enum logic {
        IT_IDLE,
        IT_ACTIVE
    } it_state_t;

    it_state_t           state;
    logic [3:0]          flags;
    logic [3:0]          it_first;
    logic [IT_MAX-1:0]   it_else;
    logic [IT_CNT_W-1:0] remaining;
    logic [IT_CNT_W-1:0] slot;

    logic [3:0]          eff_cond;
    logic [IT_CNT_W-1:0] len_eff;
    logic                else_bit;
    logic                cond_pass;
    logic                write_ok;
    logic                it_load;

    // Flags are {N,Z,C,V}; codes 1110 and 1111 both always pass.
    function automatic logic cond_passed(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cond)
            4'b0000: cond_passed = z;
            4'b0001: cond_passed = !z;
            4'b0010: cond_passed = c;
            4'b0011: cond_passed = !c;
            4'b0100: cond_passed = n;
            4'b0101: cond_passed = !n;
            4'b0110: cond_passed = v;
            4'b0111: cond_passed = !v;
            4'b1000: cond_passed = c && !z;
            4'b1001: cond_passed = !c || z;
            4'b1010: cond_passed = (n == v);
            4'b1011: cond_passed = (n != v);
            4'b1100: cond_passed = !z && (n == v);
            4'b1101: cond_passed = z || (n != v);
            default: cond_passed = 1'b1;
        endcase
    endfunction

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        else_bit = 1'b0;
        for (int i = 0; i < IT_MAX; i++) begin
            if (slot == IT_CNT_W'(i)) begin
                else_bit = it_else[i] && (i != 0);
            end
        end

        eff_cond = i_Cond;
        if (state == IT_ACTIVE) begin
            if (it_first == 4'b1110) begin
                eff_cond = it_first;
            end else begin
                eff_cond = {it_first[3:1], it_first[0] ^ else_bit};
            end
        end

        if (i_IT_Len == '0) begin
            len_eff = IT_CNT_W'(1);
        end else if (i_IT_Len > IT_CNT_W'(IT_MAX)) begin
            len_eff = IT_CNT_W'(IT_MAX);
        end else begin
            len_eff = i_IT_Len;
        end
    end

    assign cond_pass   = cond_passed(eff_cond, flags);
    assign o_Cond_Ex   = i_Valid & ~i_Flush & cond_pass;
    // The IT instruction itself never writes anything.
    assign write_ok    = o_Cond_Ex & ~i_IT_Start;
    assign o_PC_Src    = i_PC_Src & write_ok;
    assign o_Mem_Write = i_Mem_Write & write_ok;
    assign o_Reg_Write = i_Reg_Write & ~i_No_Write & write_ok;
    assign it_load     = i_Valid & i_IT_Start & ~i_Flush;

    assign o_Flags        = flags;
    assign o_IT_Active    = (state == IT_ACTIVE);
    assign o_IT_Remaining = remaining;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            flags     <= FLAG_RESET;
            state     <= IT_IDLE;
            it_first  <= 4'b1110;
            it_else   <= '0;
            remaining <= '0;
            slot      <= '0;
        end else if (!i_Stall) begin
            if (write_ok) begin
                if (i_Flag_Write[1]) flags[3:2] <= i_ALU_Flags[3:2];
                if (i_Flag_Write[0]) flags[1:0] <= i_ALU_Flags[1:0];
            end

            if (it_load) begin
                state     <= IT_ACTIVE;
                it_first  <= i_IT_FirstCond;
                it_else   <= i_IT_Else;
                remaining <= len_eff;
                slot      <= '0;
            end else if (state == IT_ACTIVE) begin
                // A flush or a taken branch discards the rest of the IT shadow.
                if (i_Flush || o_PC_Src) begin
                    state     <= IT_IDLE;
                    remaining <= '0;
                    slot      <= '0;
                end else if (i_Valid) begin
                    if (remaining == IT_CNT_W'(1)) begin
                        state     <= IT_IDLE;
                        remaining <= '0;
                        slot      <= '0;
                    end else begin
                        remaining <= remaining - IT_CNT_W'(1);
                        slot      <= slot + IT_CNT_W'(1);
                    end
                end
            end
        end
    end

`ifdef ARM_COND_STICKY_Q_EN
    logic q_flag;

    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            q_flag <= 1'b0;
        end else if (!i_Stall && o_Cond_Ex) begin
            if (i_Q_Clear) begin
                q_flag <= 1'b0;
            end else if (i_Sat) begin
                q_flag <= 1'b1;
            end
        end
    end

    assign o_Q_Flag = q_flag;
`endif

endmodule

// File: tb/tb_arm_pipelined_cond_exec_unit.sv
// Directed self-checking bench for arm_pipelined_cond_exec_unit: flag update, condition decode,
// output gating, IT sequencing with stall/bubble/flush/branch/reset, and the sticky Q flag when enabled.
module tb_arm_pipelined_cond_exec_unit;

    localparam int IT_MAX   = 4;
    localparam int IT_CNT_W = $clog2(IT_MAX + 1);

    logic                i_CLK = 1'b0;
    logic                i_RESET;
    logic                i_Valid, i_Stall, i_Flush;
    logic [3:0]          i_Cond, i_ALU_Flags, i_IT_FirstCond;
    logic [1:0]          i_Flag_Write;
    logic                i_PC_Src, i_Reg_Write, i_Mem_Write, i_No_Write, i_IT_Start;
    logic [IT_CNT_W-1:0] i_IT_Len;
    logic [IT_MAX-1:0]   i_IT_Else;
    logic                o_Cond_Ex, o_PC_Src, o_Reg_Write, o_Mem_Write, o_IT_Active;
    logic [3:0]          o_Flags;
    logic [IT_CNT_W-1:0] o_IT_Remaining;
`ifdef ARM_COND_STICKY_Q_EN
    logic                i_Sat, i_Q_Clear, o_Q_Flag;
`endif

    int total = 0;
    int bad   = 0;

    arm_pipelined_cond_exec_unit #(.IT_MAX(IT_MAX), .FLAG_RESET(4'b0000)) dut (
        .i_CLK(i_CLK), .i_RESET(i_RESET), .i_Valid(i_Valid), .i_Stall(i_Stall), .i_Flush(i_Flush),
        .i_Cond(i_Cond), .i_ALU_Flags(i_ALU_Flags), .i_Flag_Write(i_Flag_Write),
        .i_PC_Src(i_PC_Src), .i_Reg_Write(i_Reg_Write), .i_Mem_Write(i_Mem_Write),
        .i_No_Write(i_No_Write), .i_IT_Start(i_IT_Start), .i_IT_FirstCond(i_IT_FirstCond),
        .i_IT_Len(i_IT_Len), .i_IT_Else(i_IT_Else),
`ifdef ARM_COND_STICKY_Q_EN
        .i_Sat(i_Sat), .i_Q_Clear(i_Q_Clear), .o_Q_Flag(o_Q_Flag),
`endif
        .o_Cond_Ex(o_Cond_Ex), .o_PC_Src(o_PC_Src), .o_Reg_Write(o_Reg_Write),
        .o_Mem_Write(o_Mem_Write), .o_Flags(o_Flags), .o_IT_Active(o_IT_Active),
        .o_IT_Remaining(o_IT_Remaining)
    );

    always #5 i_CLK = ~i_CLK;

    task automatic idle();
        i_Valid = 0; i_Stall = 0; i_Flush = 0; i_Cond = 4'hE; i_ALU_Flags = 0;
        i_Flag_Write = 0; i_PC_Src = 0; i_Reg_Write = 0; i_Mem_Write = 0; i_No_Write = 0;
        i_IT_Start = 0; i_IT_FirstCond = 0; i_IT_Len = 0; i_IT_Else = 0;
`ifdef ARM_COND_STICKY_Q_EN
        i_Sat = 0; i_Q_Clear = 0;
`endif
    endtask

    task automatic step();
        @(posedge i_CLK);
        #1;
    endtask

    task automatic do_reset();
        idle();
        i_RESET = 1;
        step();
        i_RESET = 0;
    endtask

    task automatic load_flags(input logic [3:0] f);
        idle();
        i_Valid = 1; i_Cond = 4'hE; i_ALU_Flags = f; i_Flag_Write = 2'b11;
        step();
        idle();
    endtask

    task automatic it_start(input logic [3:0] fc, input logic [IT_CNT_W-1:0] len, input logic [IT_MAX-1:0] els);
        idle();
        i_Valid = 1; i_IT_Start = 1; i_IT_FirstCond = fc; i_IT_Len = len; i_IT_Else = els;
    endtask

    task automatic test_reset();
        idle();
        i_Valid = 1; i_Reg_Write = 1; i_Flag_Write = 2'b11; i_ALU_Flags = 4'hF;
        i_RESET = 1;
        step();
        i_RESET = 0;
        idle();
        #1;
        total++; if (o_Flags !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", o_Flags); end
        total++; if (o_IT_Active !== 1'b0) begin bad++; $display("FAIL reset_it_active got=%b exp=0", o_IT_Active); end
        total++; if (o_IT_Remaining !== 3'd0) begin bad++; $display("FAIL reset_remaining got=%0d exp=0", o_IT_Remaining); end
        i_Reg_Write = 1; i_Mem_Write = 1; #1;
        total++; if (o_Reg_Write !== 1'b0 || o_Mem_Write !== 1'b0) begin bad++; $display("FAIL reset_novalid_writes got=%b%b exp=00", o_Reg_Write, o_Mem_Write); end
    endtask

    task automatic test_cmp_eq();
        do_reset();
        i_Valid = 1; i_Cond = 4'hE; i_ALU_Flags = 4'b0100; i_Flag_Write = 2'b11; i_No_Write = 1; i_Reg_Write = 1;
        #1;
        total++; if (o_Reg_Write !== 1'b0) begin bad++; $display("FAIL cmp_nowrite got=%b exp=0", o_Reg_Write); end
        step();
        idle();
        total++; if (o_Flags !== 4'b0100) begin bad++; $display("FAIL cmp_flags got=%b exp=0100", o_Flags); end
        i_Valid = 1; i_Reg_Write = 1; i_Cond = 4'b0000; #1;
        total++; if (o_Reg_Write !== 1'b1) begin bad++; $display("FAIL eq_regwrite got=%b exp=1", o_Reg_Write); end
        i_Cond = 4'b0001; #1;
        total++; if (o_Reg_Write !== 1'b0) begin bad++; $display("FAIL ne_regwrite got=%b exp=0", o_Reg_Write); end
        // Partial flag writes: NZ only, then CV only.
        load_flags(4'b1001);
        i_Valid = 1; i_Cond = 4'hE; i_ALU_Flags = 4'b0110; i_Flag_Write = 2'b10;
        step();
        total++; if (o_Flags !== 4'b0101) begin bad++; $display("FAIL fw_nz got=%b exp=0101", o_Flags); end
        i_ALU_Flags = 4'b1010; i_Flag_Write = 2'b01;
        step();
        total++; if (o_Flags !== 4'b0110) begin bad++; $display("FAIL fw_cv got=%b exp=0110", o_Flags); end
    endtask

    task automatic test_cond_table();
        logic [15:0] exp;
        do_reset();
        load_flags(4'b1001);
        exp = 16'hD65A;
        i_Valid = 1;
        for (int c = 0; c < 16; c++) begin
            i_Cond = 4'(c); #1;
            total++; if (o_Cond_Ex !== exp[c]) begin bad++; $display("FAIL cond_1001_%0d got=%b exp=%b", c, o_Cond_Ex, exp[c]); end
        end
        load_flags(4'b0110);
        exp = 16'hE6A5;
        i_Valid = 1;
        for (int c = 0; c < 16; c++) begin
            i_Cond = 4'(c); #1;
            total++; if (o_Cond_Ex !== exp[c]) begin bad++; $display("FAIL cond_0110_%0d got=%b exp=%b", c, o_Cond_Ex, exp[c]); end
        end
    endtask

    task automatic test_gt_flush();
        do_reset();
        i_Valid = 1; i_Cond = 4'b1100; i_Mem_Write = 1; i_Flag_Write = 2'b11; i_ALU_Flags = 4'b1111;
        #1;
        total++; if (o_Mem_Write !== 1'b1) begin bad++; $display("FAIL gt_memwrite got=%b exp=1", o_Mem_Write); end
        i_Flush = 1; #1;
        total++; if (o_Mem_Write !== 1'b0) begin bad++; $display("FAIL flush_memwrite got=%b exp=0", o_Mem_Write); end
        step();
        total++; if (o_Flags !== 4'b0000) begin bad++; $display("FAIL flush_flags got=%b exp=0000", o_Flags); end
        i_Flush = 0; i_Stall = 1;
        step();
        total++; if (o_Flags !== 4'b0000) begin bad++; $display("FAIL stall_flags got=%b exp=0000", o_Flags); end
        i_Stall = 0;
        step();
        total++; if (o_Flags !== 4'b1111) begin bad++; $display("FAIL gt_flags got=%b exp=1111", o_Flags); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        // ALU flags of the current instruction never feed its own condition.
        i_Valid = 1; i_Cond = 4'b0000; i_ALU_Flags = 4'b0100; i_Flag_Write = 2'b11; #1;
        total++; if (o_Cond_Ex !== 1'b0) begin bad++; $display("FAIL registered_flags_only got=%b exp=0", o_Cond_Ex); end
        step();
        total++; if (o_Flags !== 4'b0000) begin bad++; $display("FAIL failed_no_update got=%b exp=0000", o_Flags); end
        i_Cond = 4'hE;
        step();
        i_Cond = 4'b0000; i_Reg_Write = 1; i_ALU_Flags = 4'b0000; #1;
        total++; if (o_Reg_Write !== 1'b1) begin bad++; $display("FAIL b2b_eq1 got=%b exp=1", o_Reg_Write); end
        step();
        total++; if (o_Reg_Write !== 1'b0) begin bad++; $display("FAIL b2b_eq2 got=%b exp=0", o_Reg_Write); end
    endtask

    task automatic test_it_basic();
        do_reset();
        load_flags(4'b0100);
        it_start(4'b0000, 3'd3, 4'b0100);
        i_Reg_Write = 1; i_Mem_Write = 1; i_PC_Src = 1; i_Cond = 4'hE; #1;
        total++; if ({o_Reg_Write, o_Mem_Write, o_PC_Src} !== 3'b000) begin bad++; $display("FAIL it_instr_writes got=%b exp=000", {o_Reg_Write, o_Mem_Write, o_PC_Src}); end
        step();
        total++; if (o_IT_Active !== 1'b1 || o_IT_Remaining !== 3'd3) begin bad++; $display("FAIL it_load got=%b/%0d exp=1/3", o_IT_Active, o_IT_Remaining); end
        idle();
        i_Valid = 1; i_Reg_Write = 1; i_Cond = 4'b0001; #1;
        total++; if (o_Reg_Write !== 1'b1) begin bad++; $display("FAIL it_slot0 got=%b exp=1", o_Reg_Write); end
        step();
        total++; if (o_IT_Remaining !== 3'd2) begin bad++; $display("FAIL it_rem2 got=%0d exp=2", o_IT_Remaining); end
        total++; if (o_Reg_Write !== 1'b1) begin bad++; $display("FAIL it_slot1 got=%b exp=1", o_Reg_Write); end
        step();
        total++; if (o_IT_Remaining !== 3'd1) begin bad++; $display("FAIL it_rem1 got=%0d exp=1", o_IT_Remaining); end
        total++; if (o_Reg_Write !== 1'b0) begin bad++; $display("FAIL it_slot2_else got=%b exp=0", o_Reg_Write); end
        step();
        total++; if (o_IT_Active !== 1'b0 || o_IT_Remaining !== 3'd0) begin bad++; $display("FAIL it_done got=%b/%0d exp=0/0", o_IT_Active, o_IT_Remaining); end
        i_Cond = 4'b0000; #1;
        total++; if (o_Reg_Write !== 1'b1) begin bad++; $display("FAIL it_after_idle got=%b exp=1", o_Reg_Write); end
        // Len 0 acts as 1; Else bit 0 never inverts slot 0.
        it_start(4'b0000, 3'd0, 4'b0001);
        step();
        total++; if (o_IT_Remaining !== 3'd1) begin bad++; $display("FAIL it_len0 got=%0d exp=1", o_IT_Remaining); end
        idle();
        i_Valid = 1; i_Reg_Write = 1; i_Cond = 4'b0001; #1;
        total++; if (o_Reg_Write !== 1'b1) begin bad++; $display("FAIL it_else_bit0 got=%b exp=1", o_Reg_Write); end
        step();
        total++; if (o_IT_Active !== 1'b0) begin bad++; $display("FAIL it_len0_done got=%b exp=0", o_IT_Active); end
    endtask

    task automatic test_it_stall_bubble();
        do_reset();
        it_start(4'b1110, 3'd4, 4'b0000);
        step();
        total++; if (o_IT_Remaining !== 3'd4) begin bad++; $display("FAIL itsb_load got=%0d exp=4", o_IT_Remaining); end
        idle();
        i_Valid = 1; i_Reg_Write = 1;
        step();
        total++; if (o_IT_Remaining !== 3'd3) begin bad++; $display("FAIL itsb_first got=%0d exp=3", o_IT_Remaining); end
        idle();
        step();
        total++; if (o_IT_Remaining !== 3'd3 || o_IT_Active !== 1'b1) begin bad++; $display("FAIL itsb_bubble got=%0d/%b exp=3/1", o_IT_Remaining, o_IT_Active); end
        i_Valid = 1; i_Stall = 1; i_Reg_Write = 1; i_Flag_Write = 2'b11; i_ALU_Flags = 4'b1010; #1;
        total++; if (o_Reg_Write !== 1'b1) begin bad++; $display("FAIL itsb_stall_out got=%b exp=1", o_Reg_Write); end
        step();
        total++; if (o_IT_Remaining !== 3'd3 || o_Flags !== 4'b0000) begin bad++; $display("FAIL itsb_stall1 got=%0d/%b exp=3/0000", o_IT_Remaining, o_Flags); end
        i_Flush = 1; #1;
        total++; if (o_Reg_Write !== 1'b0) begin bad++; $display("FAIL itsb_stallflush_out got=%b exp=0", o_Reg_Write); end
        step();
        total++; if (o_IT_Remaining !== 3'd3 || o_IT_Active !== 1'b1) begin bad++; $display("FAIL itsb_stall2 got=%0d/%b exp=3/1", o_IT_Remaining, o_IT_Active); end
        idle();
        i_Valid = 1;
        step();
        total++; if (o_IT_Remaining !== 3'd2) begin bad++; $display("FAIL itsb_second got=%0d exp=2", o_IT_Remaining); end
        step();
        total++; if (o_IT_Remaining !== 3'd1 || o_IT_Active !== 1'b1) begin bad++; $display("FAIL itsb_third got=%0d/%b exp=1/1", o_IT_Remaining, o_IT_Active); end
        step();
        total++; if (o_IT_Remaining !== 3'd0 || o_IT_Active !== 1'b0) begin bad++; $display("FAIL itsb_fourth got=%0d/%b exp=0/0", o_IT_Remaining, o_IT_Active); end
    endtask

    task automatic test_it_exit();
        do_reset();
        it_start(4'b1110, 3'd3, 4'b0000);
        step();
        idle();
        i_Valid = 1; i_PC_Src = 1; #1;
        total++; if (o_PC_Src !== 1'b1) begin bad++; $display("FAIL branch_pcsrc got=%b exp=1", o_PC_Src); end
        step();
        total++; if (o_IT_Active !== 1'b0 || o_IT_Remaining !== 3'd0) begin bad++; $display("FAIL branch_exit got=%b/%0d exp=0/0", o_IT_Active, o_IT_Remaining); end
        it_start(4'b1110, 3'd3, 4'b0000);
        step();
        idle();
        i_Valid = 1; i_Flush = 1;
        step();
        total++; if (o_IT_Active !== 1'b0) begin bad++; $display("FAIL flush_exit got=%b exp=0", o_IT_Active); end
        // Restart inside a block; oversized length clamps to IT_MAX.
        it_start(4'b1110, 3'd2, 4'b0000);
        step();
        it_start(4'b0000, 3'd7, 4'b0000);
        step();
        total++; if (o_IT_Remaining !== 3'd4 || o_IT_Active !== 1'b1) begin bad++; $display("FAIL restart_clamp got=%0d/%b exp=4/1", o_IT_Remaining, o_IT_Active); end
        do_reset();
        load_flags(4'b1111);
        it_start(4'b1110, 3'd3, 4'b0000);
        step();
        idle();
        i_Valid = 1; i_Flag_Write = 2'b11; i_ALU_Flags = 4'b1010; i_Stall = 1; i_RESET = 1;
        step();
        i_RESET = 0;
        idle();
        total++; if (o_Flags !== 4'b0000 || o_IT_Active !== 1'b0 || o_IT_Remaining !== 3'd0) begin bad++; $display("FAIL midblock_reset got=%b/%b/%0d exp=0000/0/0", o_Flags, o_IT_Active, o_IT_Remaining); end
    endtask

`ifdef ARM_COND_STICKY_Q_EN
    task automatic test_sticky_q();
        do_reset();
        total++; if (o_Q_Flag !== 1'b0) begin bad++; $display("FAIL q_reset got=%b exp=0", o_Q_Flag); end
        i_Valid = 1; i_Cond = 4'b0000; i_Sat = 1;
        step();
        total++; if (o_Q_Flag !== 1'b0) begin bad++; $display("FAIL q_failed_cond got=%b exp=0", o_Q_Flag); end
        i_Cond = 4'hE;
        step();
        total++; if (o_Q_Flag !== 1'b1) begin bad++; $display("FAIL q_set got=%b exp=1", o_Q_Flag); end
        idle();
        step();
        total++; if (o_Q_Flag !== 1'b1) begin bad++; $display("FAIL q_sticky got=%b exp=1", o_Q_Flag); end
        i_Valid = 1; i_Sat = 1; i_Q_Clear = 1;
        step();
        total++; if (o_Q_Flag !== 1'b0) begin bad++; $display("FAIL q_clear got=%b exp=0", o_Q_Flag); end
    endtask
`endif

    initial begin
        idle();
        i_RESET = 1;
        step();
        test_reset();
        test_cmp_eq();
        test_cond_table();
        test_gt_flush();
        test_back_to_back();
        test_it_basic();
        test_it_stall_bubble();
        test_it_exit();
`ifdef ARM_COND_STICKY_Q_EN
        test_sticky_q();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
